// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage controller for the 16-bit pipelined processor. Sits
// between EX/MEM and MEM/WB, drives a multi-cycle data memory through a
// request/done handshake, freezes the upstream pipeline while an access is
// outstanding, registers load data for MEM/WB and flags unaligned or
// timed-out accesses with a sticky error.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   addr       effective address from EX/MEM
//   wrData     store data from EX/MEM
//   memRead    load in MEM stage
//   memWrite   store in MEM stage (wins when both are set)
//   halt       HALT instruction in MEM stage
//   dmAddr     memory address (combinational copy of addr)
//   dmWrData   memory write data (combinational copy of wrData)
//   dmRd       one-cycle read request strobe
//   dmWr       one-cycle write request strobe
//   dmRdData   memory read data, valid with dmDone
//   dmStall    memory busy, request not accepted while high
//   dmDone     access complete, one-cycle pulse
//   dmDump     one-cycle memory dump request on the first halt
//   memoryOut  registered load data to MEM/WB
//   memStall   freeze PC..EX/MEM and bubble MEM/WB
//   memErr     sticky error: unaligned access or timeout
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wrData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        halt,
    output logic [15:0] dmAddr,
    output logic [15:0] dmWrData,
    output logic        dmRd,
    output logic        dmWr,
    input  logic [15:0] dmRdData,
    input  logic        dmStall,
    input  logic        dmDone,
    output logic        dmDump,
    output logic [15:0] memoryOut,
    output logic        memStall,
    output logic        memErr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Last WAIT count before the access is declared timed out.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] cnt;
    logic       is_read;
    logic       halted;

    logic access;
    logic unaligned;
    logic issue;

    assign access    = memRead | memWrite;
    assign unaligned = access & addr[0];
    // A request is launched only from IDLE for an aligned access the memory
    // can accept this cycle.
    assign issue     = (state == S_IDLE) & access & ~addr[0] & ~dmStall;

    assign dmAddr   = addr;
    assign dmWrData = wrData;

    // Mealy decode of strobes and stall; everything is forced low while the
    // block is held in reset so the pipeline is released immediately.
    always_comb begin
        dmRd     = 1'b0;
        dmWr     = 1'b0;
        memStall = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    // Stall on any access, including one that is back-pressured
                    // or about to fault, so the instruction never slips past.
                    memStall = access;
                    if (issue) begin
                        dmWr = memWrite;
                        dmRd = ~memWrite;
                    end
                end
                S_WAIT:  memStall = 1'b1;
                S_DONE:  memStall = 1'b0;
                default: memStall = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (unaligned) begin
                    state_nxt = S_ERR;
                end else if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (dmDone) begin
                    state_nxt = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            is_read   <= 1'b0;
            memoryOut <= 16'h0000;
            memErr    <= 1'b0;
            dmDump    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state  <= state_nxt;
            dmDump <= 1'b0;

            // Remember the kind of access so the completion does not depend on
            // the EX/MEM inputs staying put.
            if (issue) begin
                cnt     <= 8'd0;
                is_read <= ~memWrite;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 8'd1;
            end

            if ((state == S_WAIT) && dmDone && is_read) begin
                memoryOut <= dmRdData;
            end

            if (state_nxt == S_ERR) begin
                memErr <= 1'b1;
            end

            // A halt that arrives with an access waits until the access has
            // completed and the FSM is back in IDLE.
            if ((state == S_IDLE) && halt && !access && !halted) begin
                dmDump <= 1'b1;
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Randomized scoreboard bench for mem_stage (TIMEOUT=4). The stimulus side
// plays the data memory from a word array, pushes each access's expected
// load value, strobe kind and stall length into a queue; a monitor pops and
// compares when the stage signals completion (memStall falling).
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wrData;
    logic        memRead;
    logic        memWrite;
    logic        halt;
    logic [15:0] dmAddr;
    logic [15:0] dmWrData;
    logic        dmRd;
    logic        dmWr;
    logic [15:0] dmRdData;
    logic        dmStall;
    logic        dmDone;
    logic        dmDump;
    logic [15:0] memoryOut;
    logic        memStall;
    logic        memErr;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wrData(wrData),
        .memRead(memRead), .memWrite(memWrite), .halt(halt),
        .dmAddr(dmAddr), .dmWrData(dmWrData), .dmRd(dmRd), .dmWr(dmWr),
        .dmRdData(dmRdData), .dmStall(dmStall), .dmDone(dmDone),
        .dmDump(dmDump), .memoryOut(memoryOut), .memStall(memStall),
        .memErr(memErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [15:0] data;
        int          len;
    } sb_t;

    sb_t         sb[$];
    sb_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [256];
    logic [15:0] last_out;
    int          dump_cnt;
    bit          prev_stall;
    int          run_len;
    int          rd_seen;
    int          wr_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts strobes / dump pulses / stall run length and scores each
    // completed access against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            run_len    = 0;
            rd_seen    = 0;
            wr_seen    = 0;
        end else begin
            if (dmRd) rd_seen++;
            if (dmWr) wr_seen++;
            if (dmDump) dump_cnt++;
            if (memStall) begin
                run_len++;
            end else if (prev_stall) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("memory_out", memoryOut, mon_e.data);
                    chk("done_err", memErr, 0);
                    chk("rd_pulses", rd_seen, mon_e.rd ? 1 : 0);
                    chk("wr_pulses", wr_seen, mon_e.rd ? 0 : 1);
                    chk("stall_len", run_len, mon_e.len);
                end
                run_len = 0;
                rd_seen = 0;
                wr_seen = 0;
            end
            prev_stall = memStall;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
        dmDone = 1'b0; dmStall = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        last_out = 16'h0000;
        dump_cnt = 0;
        cyc();
    endtask

    // op: 0 load, 1 store, 2 load+store (behaves as store).
    // stall: dmStall cycles before acceptance; dcyc: WAIT cycle carrying dmDone.
    task automatic do_access(input int op, input logic [15:0] a, input logic [15:0] wd,
                             input int stall, input int dcyc, input logic h);
        sb_t         e;
        logic [15:0] rdv;
        rdv  = mem[a[8:1]];
        e.rd = (op == 0);
        if (op == 0) begin
            e.data   = rdv;
            last_out = rdv;
        end else begin
            e.data      = last_out;
            mem[a[8:1]] = wd;
        end
        e.len = stall + 1 + dcyc;
        sb.push_back(e);
        addr = a; wrData = wd; halt = h;
        memRead  = (op != 1);
        memWrite = (op != 0);
        dmStall  = 1'b1;
        repeat (stall) begin
            @(negedge clk);
            chk("bp_no_strobe", {dmRd, dmWr}, 0);
            chk("bp_stall", memStall, 1);
            cyc();
        end
        dmStall = 1'b0;
        @(negedge clk);
        chk("dm_addr", dmAddr, a);
        chk("dm_wrdata", dmWrData, wd);
        cyc();
        dmStall = 1'($urandom_range(0, 1));
        for (int j = 1; j <= dcyc; j++) begin
            if (j == dcyc) begin
                dmDone   = 1'b1;
                dmRdData = (op == 0) ? rdv : 16'($urandom);
            end
            cyc();
            dmDone = 1'b0;
        end
        memRead = 1'b0; memWrite = 1'b0; dmStall = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rst = 1'b0; addr = 16'h0000; wrData = 16'h0000; memRead = 1'b0;
        memWrite = 1'b0; halt = 1'b0; dmRdData = 16'h0000; dmStall = 1'b0;
        dmDone = 1'b0; dump_cnt = 0; last_out = 16'h0000;

        // Outputs are forced quiet during reset even with an access present.
        addr = 16'h0010; memRead = 1'b1;
        @(negedge clk);
        chk("rst_dmrd", dmRd, 0);
        chk("rst_stall", memStall, 0);
        chk("rst_mout", memoryOut, 16'h0000);
        chk("rst_err", memErr, 0);
        chk("rst_dump", dmDump, 0);
        memRead = 1'b0;
        do_reset();
        @(negedge clk);
        chk("idle_stall", memStall, 0);
        chk("idle_strobes", {dmRd, dmWr}, 0);
        cyc();

        // Plan load: 2-cycle memory returning BEEF; then back-pressured store.
        mem[8] = 16'hBEEF;
        do_access(0, 16'h0010, 16'h0000, 0, 2, 1'b0);
        @(negedge clk);
        chk("beef_hold", memoryOut, 16'hBEEF);
        chk("beef_idle", memStall, 0);
        cyc();
        do_access(1, 16'h0024, 16'hA5A5, 2, 1, 1'b0);

        // Randomized traffic: loads, stores, both-set, back-pressure, latency 1..4.
        for (int i = 0; i < 40; i++) begin
            int          op;
            int          st;
            int          dc;
            logic [15:0] a;
            logic [15:0] wd;
            op = $urandom_range(0, 2);
            st = $urandom_range(0, 3);
            dc = $urandom_range(1, 4);
            a  = 16'($urandom) & 16'hFFFE;
            wd = 16'($urandom);
            do_access(op, a, wd, st, dc, 1'b0);
            if ($urandom_range(0, 1) == 1) cyc();
        end

        // dmDone on the last WAIT cycle before timeout still completes.
        do_access(0, 16'h0032, 16'h0000, 0, 4, 1'b0);
        @(negedge clk);
        chk("late_done_err", memErr, 0);
        cyc();

        // Halt alone held five cycles: exactly one dump, never repeated.
        do_reset();
        halt = 1'b1;
        repeat (5) cyc();
        halt = 1'b0;
        repeat (2) cyc();
        chk("halt_one_dump", dump_cnt, 1);
        halt = 1'b1;
        repeat (3) cyc();
        halt = 1'b0;
        cyc();
        chk("halt_no_refire", dump_cnt, 1);

        // Halt with a load: dump only after the access is done.
        do_reset();
        do_access(0, 16'h0010, 16'h0000, 1, 2, 1'b1);
        chk("halt_ld_before", dump_cnt, 0);
        repeat (2) cyc();
        chk("halt_ld_after", dump_cnt, 1);
        halt = 1'b0;

        // Reset in the middle of WAIT.
        mem[8'h20] = 16'h1234;
        do_access(0, 16'h0040, 16'h0000, 0, 1, 1'b0);
        addr = 16'h0042; memRead = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_stall", memStall, 0);
        chk("midrst_mout", memoryOut, 16'h0000);
        chk("midrst_dmrd", dmRd, 0);
        cyc();
        rst = 1'b1; memRead = 1'b0; last_out = 16'h0000;
        cyc();
        dmDone = 1'b1; dmRdData = 16'hDEAD;
        cyc();
        dmDone = 1'b0;
        @(negedge clk);
        chk("late_done_mout", memoryOut, 16'h0000);
        chk("late_done_stall", memStall, 0);
        chk("late_done_noerr", memErr, 0);
        cyc();

        // Unaligned load and store: no strobe, sticky error and stall.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            addr     = (k == 0) ? 16'h0013 : 16'h0001;
            memRead  = (k == 0);
            memWrite = (k == 1);
            @(negedge clk);
            chk("unal_no_strobe", {dmRd, dmWr}, 0);
            chk("unal_err_pre", memErr, 0);
            cyc();
            memRead = 1'b0; memWrite = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("unal_err", memErr, 1);
                chk("unal_stall", memStall, 1);
                cyc();
            end
        end

        // Timeout: no dmDone -> ERR after four WAIT cycles; dmDone then ignored.
        do_reset();
        addr = 16'h0020; memRead = 1'b1;
        @(negedge clk);
        chk("to_rd_strobe", dmRd, 1);
        cyc();
        memRead = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("to_wait_err", memErr, 0);
            chk("to_wait_stall", memStall, 1);
            cyc();
        end
        @(negedge clk);
        chk("to_err", memErr, 1);
        chk("to_err_stall", memStall, 1);
        chk("to_err_strobes", {dmRd, dmWr}, 0);
        dmDone = 1'b1; dmRdData = 16'h5555;
        cyc();
        dmDone = 1'b0;
        @(negedge clk);
        chk("to_done_ignored", memoryOut, last_out);
        chk("to_err_sticky", memErr, 1);
        cyc();
        do_reset();
        @(negedge clk);
        chk("to_err_cleared", memErr, 0);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage controller for the 16-bit pipelined processor. It sits between the EX/MEM pipeline register and the MEM/WB register. It drives a multi-cycle data memory through a request/done handshake and stalls the upstream pipeline while an access is outstanding. It also delivers registered read data as `memoryOut` to MEM/WB and flags unaligned or timed-out accesses.

## Interface
- `TIMEOUT`, default 16: maximum WAIT cycles before an access is declared failed (range 2–255).
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset. The block uses one clock, and reset is asynchronous and active-low.
- `addr`  in  16  effective address (ALU result from EX/MEM).
- `wrData`  in  16  store data.
- `memRead`  in  1  load in MEM stage.
- `memWrite`  in  1  store in MEM stage.
- `halt`  in  1  HALT instruction in MEM stage.
- `dmAddr`  out  16  memory address; equals `addr` combinationally.
- `dmWrData`  out  16  memory write data; equals `wrData` combinationally.
- `dmRd`  out  1  read request strobe.
- `dmWr`  out  1  write request strobe.
- `dmRdData`  in  16  memory read data, valid with `dmDone`.
- `dmStall`  in  1  memory busy; a request is not accepted while high.
- `dmDone`  in  1  access complete, one-cycle pulse.
- `dmDump`  out  1  one-cycle pulse requesting a memory dump on halt.
- `memoryOut`  out  16  registered load data to MEM/WB.
- `memStall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM, and bubble MEM/WB.
- `memErr`  out  1  sticky error: unaligned access or timeout.

## Operation
- States: IDLE, WAIT, DONE, ERR. An 8-bit wait counter `cnt` runs during WAIT.
- "Access" means `memRead | memWrite`. "Unaligned" means access with `addr[0]=1`. If both `memRead` and `memWrite` are high, the access is treated as a write.
- IDLE, no access: `memStall=0`, no strobes.
- IDLE, unaligned: go to ERR and issue no strobe.
- IDLE, aligned access, `dmStall=1`: `memStall=1`, no strobe, stay in IDLE.
- IDLE, aligned access, `dmStall=0`:
  - assert `dmRd` (read) or `dmWr` (write) for this cycle only;
  - `memStall=1`;
  - go to WAIT with `cnt=0`.
- WAIT: `memStall=1`, no strobes, `cnt` increments each cycle.
  - On `dmDone`: a read loads `dmRdData` into `memoryOut`; a write leaves `memoryOut` unchanged. Go to DONE.
  - Otherwise, when `cnt` reaches TIMEOUT-1 the next state is ERR.
  - If `dmDone` arrives on the same cycle the timeout would fire, `dmDone` wins.
- DONE: `memStall=0` for exactly one cycle, so the pipeline advances past the access. The next state is IDLE unconditionally.
- ERR: absorbing until reset.
  - `memErr=1`, `memStall=1`, no strobes.
  - `dmDone` is ignored.
- `dmDone` in any state other than WAIT is ignored.
- Halt: in IDLE with `halt=1`, no access, and the internal `halted` flag clear, pulse `dmDump` for one cycle and set `halted`. `dmDump` never fires again until reset.
- A halt coincident with an access is serviced after the access completes, on return to IDLE.
- `memoryOut` holds its last value across non-load instructions.

## Timing
- Strobes and `memStall` are decoded from the state and current inputs (Mealy). `memoryOut`, `memErr`, `dmDump` and the state are registered.
- Minimum access cost is 3 cycles: request cycle, ≥1 WAIT cycle, DONE. `memStall` is high for (1 + WAIT cycles); a back-pressured IDLE adds one cycle per `dmStall` cycle.
- Load data appears on `memoryOut` on the clock edge that enters DONE, so it is stable during DONE, when MEM/WB captures it.
- Reset values: state IDLE, `cnt=0`, `memoryOut=16'h0000`, `memErr=0`, `dmDump=0`, `halted=0`. With `rst=0` the block also forces `dmRd=0`, `dmWr=0` and `memStall=0` asynchronously.
- Reset asserted mid-WAIT abandons the access immediately. A late `dmDone` after reset is ignored.

## Test plan
- Load, 2-cycle memory: `addr=16'h0010`, `memRead=1`; `dmDone` with `dmRdData=16'hBEEF` two cycles after the `dmRd` pulse -> `dmRd` high for 1 cycle, `memStall` high for 3 cycles, `memoryOut=16'hBEEF` in DONE, back in IDLE the next cycle.
- Store with back-pressure: `memWrite=1`, `dmStall=1` for 2 cycles -> no `dmWr` while `dmStall=1`, then a single `dmWr` pulse; `memoryOut` unchanged.
- Unaligned: `addr=16'h0013`, `memRead=1` -> no `dmRd`; `memErr=1` and `memStall=1` from the next cycle, held until reset.
- Timeout: TIMEOUT=4, `dmDone` never arrives -> ERR entered after 4 WAIT cycles. A second run with `dmDone` on WAIT cycle 4 -> DONE, `memErr=0`.
- Halt: `halt=1` held for 5 cycles with no access -> exactly one `dmDump` pulse. Halt together with a load -> `dmDump` only after DONE.
- Reset mid-WAIT: `rst=0` one cycle after `dmRd` -> `memStall=0` and `memoryOut=16'h0000` asynchronously; a `dmDone` arriving afterwards is ignored.
